// File: rtl/wallace_pkg.sv
// Shared widths, FSM state encoding and the carry-save helper used by the
// Wallace multiplier scheduler and its reduction stage.
package wallace_pkg;

    localparam int OPW = 5;   // operand width
    localparam int PW  = 10;  // product width

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        ADD    = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Sum and carry rows produced by one 3:2 compressor layer.
    typedef struct packed {
        logic [PW-1:0] sum;
        logic [PW-1:0] carry;
    } csa_t;

    // Bitwise 3:2 compression of three rows. The carry row is shifted left
    // one place. Anything shifted past PW is dropped. This is safe because
    // the product fits in PW bits and the sum is exact modulo 2**PW.
    function automatic csa_t csa(input logic [PW-1:0] x,
                                 input logic [PW-1:0] y,
                                 input logic [PW-1:0] z);
        csa_t r;
        r.sum   = x ^ y ^ z;
        r.carry = ((x & y) | (x & z) | (y & z)) << 1;
        return r;
    endfunction

endpackage

// File: rtl/wallace_tree_reduction.sv
// Combinational Wallace reduction of an OPW x OPW unsigned multiply.
// It reduces the partial products down to two PW-bit rows. The sum of the
// two rows equals a*b.
module wallace_tree_reduction
    import wallace_pkg::*;
(
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic [PW-1:0]  r1,
    output logic [PW-1:0]  r2
);

    logic [PW-1:0] w_pp [OPW];
    csa_t          w_l1;
    csa_t          w_l2;
    csa_t          w_l3;

    // Build the partial-product rows: row i is a shifted by i, gated by b[i].
    // NOTE: every always_comb output gets a value on every path (here via the
    // full loop), otherwise synthesis infers a latch.
    always_comb begin
        for (int i = 0; i < OPW; i++) begin
            w_pp[i] = {PW{b[i]}} & (PW'(a) << i);
        end
    end

    // Three compressor layers take five rows down to two:
    // {pp0, pp1, pp2}, then {s1, c1, pp3}, then {s2, c2, pp4}.
    always_comb begin
        w_l1 = csa(w_pp[0], w_pp[1], w_pp[2]);
        w_l2 = csa(w_l1.sum, w_l1.carry, w_pp[3]);
        w_l3 = csa(w_l2.sum, w_l2.carry, w_pp[4]);
    end

    assign r1 = w_l3.sum;
    assign r2 = w_l3.carry;

endmodule

// File: rtl/wallace_mul_sched.sv
// Two-requester scheduler in front of a Wallace-tree multiplier.
// It arbitrates round-robin between requester 0 and requester 1.
// Each job passes through REDUCE, then ADD, then DONE.
// The result is held in DONE until the consumer takes it.
module wallace_mul_sched
    import wallace_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    input  logic [OPW-1:0] req0_a,
    input  logic [OPW-1:0] req0_b,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [OPW-1:0] req1_a,
    input  logic [OPW-1:0] req1_b,
    output logic           req1_ready,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [PW-1:0]  res_prod,
    output logic           res_id,
    output logic           busy,
    output logic [7:0]     done_cnt
);

    state_t         r_state;
    state_t         w_next_state;
    logic [OPW-1:0] r_a;
    logic [OPW-1:0] r_b;
    logic           r_id;
    logic           r_last;      // last granted requester
    logic [PW-1:0]  r_row1;
    logic [PW-1:0]  r_row2;
    logic [PW-1:0]  r_prod;
    logic [7:0]     r_done_cnt;
    logic           w_grant;
    logic           w_grant_id;
    logic [PW-1:0]  w_r1;
    logic [PW-1:0]  w_r2;

    wallace_tree_reduction u_reduce (
        .a  (r_a),
        .b  (r_b),
        .r1 (w_r1),
        .r2 (w_r2)
    );

    // Arbitration and next-state decode.
    // Ready is only ever offered in IDLE, and never while reset is high.
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_grant_id   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!rst) begin
                    if (req0_valid && req1_valid) begin
                        w_grant    = 1'b1;
                        w_grant_id = ~r_last;
                    end else if (req0_valid) begin
                        w_grant    = 1'b1;
                        w_grant_id = 1'b0;
                    end else if (req1_valid) begin
                        w_grant    = 1'b1;
                        w_grant_id = 1'b1;
                    end
                end
                if (w_grant) w_next_state = REDUCE;
            end
            REDUCE: w_next_state = ADD;
            ADD:    w_next_state = DONE;
            DONE:   if (res_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign req0_ready = w_grant & ~w_grant_id;
    assign req1_ready = w_grant &  w_grant_id;

    // State register. The reset value of r_last makes requester 0 win the
    // first contention.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next_state;
            if (w_grant) r_last <= w_grant_id;
        end
    end

    // Datapath pipeline: capture operands on grant, capture rows in REDUCE,
    // and add the rows in ADD. The registers hold their values otherwise.
    // NOTE: these are plain registers, not memories, so all of them are reset
    // to keep the first result and the outputs deterministic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_id   <= 1'b0;
            r_row1 <= '0;
            r_row2 <= '0;
            r_prod <= '0;
        end else begin
            if (w_grant) begin
                r_a  <= w_grant_id ? req1_a : req0_a;
                r_b  <= w_grant_id ? req1_b : req0_b;
                r_id <= w_grant_id;
            end
            if (r_state == REDUCE) begin
                r_row1 <= w_r1;
                r_row2 <= w_r2;
            end
            if (r_state == ADD) begin
                r_prod <= r_row1 + r_row2;
            end
        end
    end

    // Count completed result handshakes. The counter wraps naturally at 8 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done_cnt <= 8'd0;
        end else if (r_state == DONE && res_ready) begin
            r_done_cnt <= r_done_cnt + 8'd1;
        end
    end

    assign res_valid = (r_state == DONE);
    assign res_prod  = r_prod;
    assign res_id    = r_id;
    assign busy      = (r_state != IDLE);
    assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_wallace_mul_sched.sv
// Scoreboard bench for wallace_mul_sched.
// The drivers push the expected {id, product} into a queue when a requester
// is accepted. The monitor pops and compares on every result handshake.
module tb_wallace_mul_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [4:0] req0_a, req0_b, req1_a, req1_b;
    logic       req0_ready, req1_ready;
    logic       res_valid, res_ready;
    logic [9:0] res_prod;
    logic       res_id;
    logic       busy;
    logic [7:0] done_cnt;

    typedef struct {
        logic       id;
        logic [9:0] prod;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    wallace_mul_sched dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_prod   (res_prod),
        .res_id     (res_id),
        .busy       (busy),
        .done_cnt   (done_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input bit ok, input int act, input int exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: compares every handshake against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (q.size() == 0) begin
                check("unexpected_result", 1'b0, int'(res_prod), -1);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("res_prod", res_prod == e.prod, int'(res_prod), int'(e.prod));
                check("res_id", res_id == e.id, int'(res_id), int'(e.id));
            end
        end
    end

    function automatic logic rdy(input int id);
        return (id == 0) ? req0_ready : req1_ready;
    endfunction

    task automatic set_req(input int id, input logic v, input logic [4:0] a, input logic [4:0] b);
        if (id == 0) begin
            req0_valid = v; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b;
        end
    endtask

    // Issue one job. The expected result is pushed on acceptance.
    // If chk_lat is set, the task also checks the one-cycle ready pulse and
    // the 3-cycle latency to res_valid.
    task automatic job(input int id, input logic [4:0] a, input logic [4:0] b,
                       input logic [9:0] exp, input bit push, input bit chk_lat);
        bit got;
        int lat;
        got = 1'b0;
        @(posedge clk); #1;
        set_req(id, 1'b1, a, b);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rdy(id)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check("accept_timeout", 1'b0, 0, 1);
            set_req(id, 1'b0, 5'd0, 5'd0);
            return;
        end
        if (push) begin
            exp_t e;
            e.id   = id[0];
            e.prod = exp;
            q.push_back(e);
        end
        @(posedge clk); #1;
        if (chk_lat) begin
            @(negedge clk);
            check("ready_one_cycle", rdy(id) == 1'b0, int'(rdy(id)), 0);
            set_req(id, 1'b0, 5'($urandom), 5'($urandom));
            lat = 0;
            for (int i = 2; i <= 10; i++) begin
                @(negedge clk);
                if (res_valid) begin
                    lat = i;
                    break;
                end
            end
            check("latency", lat == 3, lat, 3);
        end else begin
            set_req(id, 1'b0, 5'($urandom), 5'($urandom));
        end
    endtask

    // Wait for the DUT to go idle, then compare done_cnt.
    task automatic check_cnt(input string name, input int exp);
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!busy) begin
                idle = 1'b1;
                break;
            end
        end
        check({name, "_idle"}, idle, int'(busy), 0);
        check(name, done_cnt == 8'(exp), int'(done_cnt), exp);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   gnt [4];
        int   exp_gnt [4];
        int   ng;
        int   k;
        logic [4:0] sa, sb;

        exp_gnt = '{0, 1, 0, 1};
        rst = 1'b1;
        res_ready = 1'b1;
        set_req(0, 1'b1, 5'd1, 5'd1);
        set_req(1, 1'b1, 5'd2, 5'd2);

        // Reset state, with both requesters asserting valid.
        @(negedge clk);
        check("rst_ready0", req0_ready == 1'b0, int'(req0_ready), 0);
        check("rst_ready1", req1_ready == 1'b0, int'(req1_ready), 0);
        check("rst_res_valid", res_valid == 1'b0, int'(res_valid), 0);
        check("rst_busy", busy == 1'b0, int'(busy), 0);
        check("rst_res_prod", res_prod == 10'd0, int'(res_prod), 0);
        check("rst_res_id", res_id == 1'b0, int'(res_id), 0);
        check("rst_done_cnt", done_cnt == 8'd0, int'(done_cnt), 0);
        set_req(0, 1'b0, 5'd0, 5'd0);
        set_req(1, 1'b0, 5'd0, 5'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Single requester at maximum operands: 31*31 = 961.
        job(0, 5'd31, 5'd31, 10'd961, 1'b1, 1'b1);
        check_cnt("cnt_after_max", 1);

        // Contention straight after reset: grants must alternate starting at 0.
        pulse_reset();
        @(posedge clk); #1;
        set_req(0, 1'b1, 5'd3, 5'd5);
        set_req(1, 1'b1, 5'd7, 5'd9);
        ng = 0;
        for (int n = 0; n < 60 && ng < 4; n++) begin
            @(negedge clk);
            if (req0_ready && req1_ready) begin
                check("double_ready", 1'b0, 2, 1);
            end else if (req0_ready || req1_ready) begin
                exp_t e;
                e.id   = req1_ready;
                e.prod = req1_ready ? 10'd63 : 10'd15;
                q.push_back(e);
                gnt[ng] = int'(req1_ready);
                ng++;
            end
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, 5'd0, 5'd0);
        set_req(1, 1'b0, 5'd0, 5'd0);
        check("grant_count", ng == 4, ng, 4);
        for (int i = 0; i < ng; i++) begin
            check("grant_order", gnt[i] == exp_gnt[i], gnt[i], exp_gnt[i]);
        end
        check_cnt("cnt_after_rr", 4);

        // Back-pressure in DONE: 12*10 = 120 must hold stable, with no grants.
        res_ready = 1'b0;
        job(0, 5'd12, 5'd10, 10'd120, 1'b1, 1'b1);
        @(posedge clk); #1;
        set_req(0, 1'b1, 5'd4, 5'd4);
        set_req(1, 1'b1, 5'd5, 5'd5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", res_valid == 1'b1, int'(res_valid), 1);
            check("stall_prod", res_prod == 10'd120, int'(res_prod), 120);
            check("stall_id", res_id == 1'b0, int'(res_id), 0);
            check("stall_no_ready", !(req0_ready || req1_ready),
                  int'({req1_ready, req0_ready}), 0);
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, 5'd0, 5'd0);
        set_req(1, 1'b0, 5'd0, 5'd0);
        res_ready = 1'b1;
        check_cnt("cnt_after_stall", 5);

        // Zero operands on either side.
        job(0, 5'd0, 5'd31, 10'd0, 1'b1, 1'b0);
        job(1, 5'd31, 5'd0, 10'd0, 1'b1, 1'b0);
        check_cnt("cnt_after_zero", 7);

        // Reset during REDUCE: the job is discarded and the next job is clean.
        job(0, 5'd3, 5'd3, 10'd9, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_res_valid", res_valid == 1'b0, int'(res_valid), 0);
        check("midrst_busy", busy == 1'b0, int'(busy), 0);
        check("midrst_done_cnt", done_cnt == 8'd0, int'(done_cnt), 0);
        @(posedge clk); #1 rst = 1'b0;
        job(1, 5'd6, 5'd6, 10'd36, 1'b1, 1'b1);
        check_cnt("cnt_after_midrst", 1);

        // Exhaustive sweep on requester 1. done_cnt wraps every 256 handshakes.
        pulse_reset();
        k = 0;
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                sa = 5'(a);
                sb = 5'(b);
                job(1, sa, sb, 10'(a * b), 1'b1, 1'b0);
                k++;
                if (k == 256) check_cnt("cnt_wrap", 0);
            end
        end
        check_cnt("cnt_after_sweep", 0);
        check("scoreboard_empty", q.size() == 0, q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
